// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with a 2-flop synchronizer, 3-sample
// majority vote at each bit centre, false-start rejection, stop-bit framing
// check and a small circular FIFO drained by a valid/ready handshake.
// Optional feature macro: UART_RX_PARITY_EN (8E1 framing with parity check).
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_RX_Serial,
  input  logic       i_RX_Ready,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active,
  output logic       o_Framing_Err,
  output logic       o_Overrun,
  output logic       o_Parity_Err
);

  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int H     = CLKS_PER_BIT / 2;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2;

  localparam logic [CW-1:0] CNT_S0  = CW'(H - 1);
  localparam logic [CW-1:0] CNT_S1  = CW'(H);
  localparam logic [CW-1:0] CNT_MAJ = CW'(H + 1);
  localparam logic [CW-1:0] CNT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

  state_t              state_q, state_d;
  logic                rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                smp0_q, smp0_d, smp1_q, smp1_d;
  logic                fe_q, fe_d;
  logic                push;
  logic                maj, at_maj, at_end;
`ifdef UART_RX_PARITY_EN
  logic                par_bad_q, par_bad_d, pe_q, pe_d;
`endif

  logic [DEPTH-1:0][7:0] mem_q, mem_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]           count_q, count_d;
  logic                  ovr_q, ovr_d;
  logic                  dv, pop, full, wr_en;

  // Receiver FSM: bit timing, majority sampling, framing and push request
  always_comb begin
    rx_meta_d = i_RX_Serial;
    rx_s_d    = rx_meta_q;
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    shift_d   = shift_q;
    smp0_d    = smp0_q;
    smp1_d    = smp1_q;
    fe_d      = 1'b0;
    push      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    pe_d      = 1'b0;
`endif
    maj    = (smp0_q & smp1_q) | (smp0_q & rx_s_q) | (smp1_q & rx_s_q);
    at_maj = (cnt_q == CNT_MAJ);
    at_end = (cnt_q == CNT_END);
    if (cnt_q == CNT_S0) smp0_d = rx_s_q;
    if (cnt_q == CNT_S1) smp1_d = rx_s_q;
    if (at_end) cnt_d = '0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        // a start bit that does not hold low through its centre is noise
        if (at_maj && maj) state_d = S_IDLE;
        else if (at_end) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (at_maj) shift_d = {maj, shift_q[7:1]};
        if (at_end) begin
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (at_maj) begin
          par_bad_d = (maj != ^shift_q);
          pe_d      = (maj != ^shift_q);
        end
        if (at_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // decide at the stop centre so the next falling edge can be caught
        if (at_maj) begin
          if (maj) begin
`ifdef UART_RX_PARITY_EN
            push = !par_bad_q;
`else
            push = 1'b1;
`endif
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping: simultaneous push/pop always both succeed
  always_comb begin
    dv       = (count_q != '0);
    pop      = dv && i_RX_Ready;
    full     = (count_q == CNT_FULL);
    wr_en    = push && (!full || pop);
    ovr_d    = ovr_q | (push && full && !pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      smp0_q    <= 1'b1;
      smp1_q    <= 1'b1;
      fe_q      <= 1'b0;
      mem_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      pe_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      smp0_q    <= smp0_d;
      smp1_q    <= smp1_d;
      fe_q      <= fe_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      pe_q      <= pe_d;
`endif
    end
  end

  assign o_RX_DV       = dv;
  assign o_RX_Byte     = dv ? mem_q[rd_ptr_q] : 8'h00;
  assign o_RX_Active   = (state_q != S_IDLE);
  assign o_Framing_Err = fe_q;
  assign o_Overrun     = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign o_Parity_Err  = pe_q;
`else
  assign o_Parity_Err  = 1'b0;
`endif

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- 8N1 UART receiver with the noise rejection and error reporting the plain receiver lacks.
- Input path: 2-flop synchronizer, then 3-sample majority vote at each bit centre.
- Checks: false-start rejection and stop-bit framing check.
- Output: received bytes pushed into a small FIFO, drained with a valid/ready handshake.
- Sits on the serial input pin, feeding the command-parsing logic that the TX side answers.

Parameters:
- CLKS_PER_BIT, 868: clocks per bit; must be >= 4. Define H = CLKS_PER_BIT/2 (integer division).
- FIFO_DEPTH_LOG2, 2: FIFO holds 2**FIFO_DEPTH_LOG2 bytes (default 4).

Ports:
- i_Clock  input  1  system clock, all logic on rising edge.
- i_Reset  input  1  synchronous, active-high reset.
- i_RX_Serial  input  1  asynchronous serial line; idle high.
- i_RX_Ready  input  1  consumer pops the FIFO head when high while o_RX_DV is high.
- o_RX_DV  output  1  FIFO not empty.
- o_RX_Byte  output  8  FIFO head byte; valid only while o_RX_DV is high.
- o_RX_Active  output  1  high while the FSM is not in IDLE.
- o_Framing_Err  output  1  one-cycle pulse on a bad stop bit.
- o_Overrun  output  1  sticky: a byte was dropped because the FIFO was full.
- o_Parity_Err  output  1  one-cycle pulse on a parity mismatch (see Optional Feature).

Behaviour:
- Reset values: o_RX_DV=0, o_RX_Byte=0, o_RX_Active=0, o_Framing_Err=0, o_Overrun=0, o_Parity_Err=0.
- Reset also sets synchronizer flops to 1, FSM=IDLE, FIFO empty, bit counter=0.
- Reset asserted mid-frame aborts the frame; no partial byte is pushed.
- Synchronizer: two flops. "rx_s" is the second flop. Two cycles of input latency.
- Clock counter runs 0..CLKS_PER_BIT-1 within each bit period.
- Three samples are taken at counts H-1, H, H+1. The bit value is the majority of the three, decided at count H+1.
- FSM states and transitions:
  - IDLE: on rx_s==0, clear counter and go to START.
  - START: at count H+1, majority==1 means false start; return to IDLE, no output. Majority==0 continues; at count CLKS_PER_BIT-1 go to DATA, bit index=0.
  - DATA: shift the majority value in LSB first. After bit index 7 completes its period, go to STOP (or PARITY when the macro is set).
  - STOP: at count H+1, majority==1 requests a push of the byte and goes to IDLE in the same cycle.
  - STOP with majority==0: pulse o_Framing_Err, discard the byte, go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. A held-low line yields exactly one framing error.
- Re-arming: returning to IDLE at the stop-bit centre lets back-to-back frames with a single stop bit resynchronize on the next falling edge.
- FIFO: circular buffer with read and write pointers of FIFO_DEPTH_LOG2 bits and a count of FIFO_DEPTH_LOG2+1 bits. Pointers wrap modulo depth.
- Pop: occurs when o_RX_DV && i_RX_Ready. The next head appears on o_RX_Byte the following cycle.
- Push latency: o_RX_DV rises 1 cycle after the stop-bit decision cycle when the FIFO was empty.
- Push while full with no pop: byte dropped, o_Overrun set to 1 and held until i_Reset.
- Push and pop in the same cycle while full: both occur, count unchanged, no overrun.
- Push and pop in the same cycle while count==1: both occur, o_RX_DV stays high, new byte becomes head.
- i_RX_Ready while the FIFO is empty is ignored.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: frame is 8E1. A PARITY state follows DATA and samples one bit with the same majority timing.
- Defined: the sampled bit must equal the XOR of the 8 data bits (even parity).
- Defined, on mismatch: pulse o_Parity_Err for one cycle, still check the stop bit, and never push the byte.
- Not defined: frame is 8N1, no PARITY state exists, and o_Parity_Err is tied to 0.

Test Plan:
- 0x3A framed at CLKS_PER_BIT=8, i_RX_Ready=1 -> o_RX_DV for 1 cycle with o_RX_Byte=0x3A; no errors.
- 0x55 then 0xAA back-to-back with one stop bit, i_RX_Ready=0 -> two entries held; popping yields 0x55 then 0xAA, then o_RX_DV=0.
- Line low for 2 clocks (< H) in IDLE -> no o_RX_DV, no errors, FSM back in IDLE.
- Single-clock glitch at count H of a data bit in 0x37 -> majority rejects it; 0x37 received.
- 0x37 with stop bit driven 0 -> o_Framing_Err single pulse, no push; line held low 40 clocks -> still one pulse.
- 5 frames 0x01..0x05 with i_RX_Ready=0 -> o_Overrun=1; drain yields 0x01..0x04.
- Reset mid-DATA, then a 0x3A frame -> only 0x3A received.
- With UART_RX_PARITY_EN: wrong parity bit -> o_Parity_Err pulse and no push.
